// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory responder.
// Holds the FSM state encoding and helpers used by the responder and its storage.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int DEF_WAIT_CYCLES = 2;
    localparam int DEF_DEPTH_WORDS = 128;
    localparam int CNT_W           = 4;

    // Byte-address limit of a store of the given depth, as a 32-bit value.
    function automatic logic [31:0] byte_limit(input int depth_words);
        return 32'(4 * depth_words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, synchronous (registered) read.
// One-cycle read latency; no backpressure, one access per cycle.
module dmem_array #(
    parameter int DEPTH_WORDS = 128,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are deliberately left out of reset; read returns pre-write data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one MemRead/MemWrite in IDLE, waits WAIT_CYCLES, then pulses ready (with err if illegal).
// Latency WAIT_CYCLES+2 edges from acceptance to ready; requests outside IDLE are ignored, not queued.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t      state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    idx_q;
    logic [31:0]      wdata_q;
    logic             rd_q;
    logic             wr_q;
    logic             err_q;

    logic             req;
    logic             accept;
    logic             finish;
    logic             addr_err;
    logic             arr_we;
    logic [AW-1:0]    arr_idx;
    logic [31:0]      arr_rdata;

    assign req = MemRead | MemWrite;

    assign addr_err = (dAddress[1:0] != 2'b00)
                   || (dAddress >= byte_limit(DEPTH_WORDS))
                   || (MemRead && MemWrite);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            ready     <= 1'b0;
            err       <= 1'b0;
            dReadData <= '0;
        end else begin
            if (accept) begin
                cnt     <= CNT_W'(WAIT_CYCLES);
                idx_q   <= dAddress[AW+1:2];
                wdata_q <= dWriteData;
                rd_q    <= MemRead;
                wr_q    <= MemWrite;
                err_q   <= addr_err;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            ready <= finish;
            err   <= finish && err_q;

            if (finish && rd_q) begin
                dReadData <= err_q ? 32'h0 : arr_rdata;
            end
        end
    end

    // Address the array from the live bus while idle so the read data is
    // already registered by the time even a zero-wait request finishes.
    assign arr_idx = (state == IDLE) ? dAddress[AW+1:2] : idx_q;
    assign arr_we  = finish && wr_q && !err_q;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_dmem_responder;

    localparam int W     = 2;
    localparam int W0    = 0;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [31:0] dAddress, dWriteData, dReadData;
    logic        ready, err;

    logic        b_MemRead, b_MemWrite;
    logic [31:0] b_dAddress, b_dWriteData, b_dReadData;
    logic        b_ready, b_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] rdata_m;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(W), .DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .dAddress   (dAddress),
        .dWriteData (dWriteData),
        .dReadData  (dReadData),
        .ready      (ready),
        .err        (err)
    );

    dmem_responder #(.WAIT_CYCLES(W0), .DEPTH_WORDS(DEPTH)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (b_MemRead),
        .MemWrite   (b_MemWrite),
        .dAddress   (b_dAddress),
        .dWriteData (b_dWriteData),
        .dReadData  (b_dReadData),
        .ready      (b_ready),
        .err        (b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on the WAIT_CYCLES=W instance, checked against the model.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        logic e;
        int   n;
        e = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH)) || (rd && wr);
        @(negedge clk);
        MemRead    = rd;
        MemWrite   = wr;
        dAddress   = a;
        dWriteData = d;
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        n = 1;
        while (!ready && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!e && wr) mem_m[a[8:2]] = d;
        if (rd) rdata_m = e ? 32'h0 : mem_m[a[8:2]];
        check({tag, "_latency"}, n, W + 2);
        check({tag, "_err"}, {31'b0, err}, {31'b0, e});
        check({tag, "_rdata"}, dReadData, rdata_m);
        @(posedge clk);
        #1;
        check({tag, "_ready_pulse"}, {31'b0, ready}, 32'h0);
    endtask

    initial begin
        int          n;
        int          seen;
        logic [31:0] a;
        logic        rd, wr;
        int          sel, op;

        rst        = 1'b1;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        dAddress   = '0;
        dWriteData = '0;
        b_MemRead  = 1'b0;
        b_MemWrite = 1'b0;
        b_dAddress = '0;
        b_dWriteData = '0;
        rdata_m    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, ready}, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);
        check("reset_rdata", dReadData, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Give every word a known value so later reads are defined.
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b0, 1'b1, 32'(i * 4), $urandom, "init");
        end

        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr_10");
        do_req(1'b1, 1'b0, 32'h10, 32'h0, "rd_10");
        check("rd_10_value", dReadData, 32'hDEADBEEF);

        do_req(1'b1, 1'b0, 32'h13, 32'h0, "rd_misaligned");
        check("rd_misaligned_zero", dReadData, 32'h0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, "rd_10_again");
        check("rd_10_again_value", dReadData, 32'hDEADBEEF);

        do_req(1'b1, 1'b0, 32'h0, 32'h0, "rd_0_before");
        do_req(1'b0, 1'b1, 32'h200, 32'h12345678, "wr_oob");
        do_req(1'b1, 1'b0, 32'h0, 32'h0, "rd_0_after");

        do_req(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, "both");
        do_req(1'b1, 1'b0, 32'h10, 32'h0, "rd_10_after_both");
        check("rd_10_after_both_value", dReadData, 32'hDEADBEEF);

        // Reset in the middle of a write must abort it.
        do_req(1'b0, 1'b1, 32'h20, 32'h11111111, "wr_20");
        @(negedge clk);
        MemWrite   = 1'b1;
        dAddress   = 32'h20;
        dWriteData = 32'h22222222;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", {31'b0, ready}, 32'h0);
        check("abort_rdata", dReadData, 32'h0);
        rdata_m = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        check("abort_no_ready", seen, 0);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, "rd_20");
        check("rd_20_value", dReadData, 32'h11111111);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 7)      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (sel == 8) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 1000) * 4);
            else               a = 32'($urandom_range(0, DEPTH - 1) * 4);
            op = $urandom_range(0, 5);
            rd = (op <= 2) || (op == 5);
            wr = (op >= 3);
            do_req(rd, wr, a, $urandom, "rand");
        end

        // Zero-wait instance: write, then a read held high through ready.
        @(negedge clk);
        b_MemWrite   = 1'b1;
        b_dAddress   = 32'h40;
        b_dWriteData = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        b_MemWrite = 1'b0;
        n = 1;
        while (!b_ready && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("w0_wr_latency", n, W0 + 2);
        check("w0_wr_err", {31'b0, b_err}, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        b_MemRead  = 1'b1;
        b_dAddress = 32'h40;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("w0_held_ready_%0d", i), {31'b0, b_ready},
                  {31'b0, (i == W0 + 2) || (i == 2 * (W0 + 2) + 1)});
            if ((i == W0 + 2) || (i == 2 * (W0 + 2) + 1))
                check($sformatf("w0_held_rdata_%0d", i), b_dReadData, 32'hA5A5A5A5);
        end
        b_MemRead = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
